branch_pc_unit: RTL

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

---
 rtl/branch_pc_unit_pkg.sv | 22 ++
 rtl/branch_target_calc.sv | 24 ++
 rtl/branch_pc_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/branch_pc_unit_pkg.sv
// Shared types and constants for the branch/PC unit.
package branch_pc_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned STAT_W  = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } pc_state_e;

  // Control-flow flags of the instruction being executed
  typedef struct packed {
    logic branch;
    logic branch_flag;
    logic jump;
    logic jalr;
  } ctrl_t;

endpackage

// File: rtl/branch_target_calc.sv
// Next-PC priority mux (JALR > JAL > taken branch > sequential) and alignment check.
module branch_target_calc
  import branch_pc_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  ctrl_t           ctrl,
  output logic [XLEN-1:0] target_c,
  output logic            misaligned_c
);

  always_comb begin
    target_c = pc + XLEN'(PC_STEP);
    if (ctrl.jalr) begin
      target_c = (rs1 + imm) & ~XLEN'(1);
    end else if (ctrl.jump || (ctrl.branch && ctrl.branch_flag)) begin
      target_c = pc + imm;
    end
  end

  assign misaligned_c = |target_c[1:0];

endmodule

// File: rtl/branch_pc_unit.sv
// PC register and fetch/execute/trap sequencer.
// Define BRANCH_STATS_EN to build the saturating branch/taken counters.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              branch_i,
  input  logic              branchFlag_i,
  input  logic              jump_i,
  input  logic              jalr_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic              stall_i,
  input  logic              imemAck_i,
  output logic              imemReq_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pcPlus4_o,
  output logic              misaligned_o,
  output logic [STAT_W-1:0] branchCount_o,
  output logic [STAT_W-1:0] takenCount_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] target;
  logic            target_mis;
  logic            imem_req_d;
  logic            misaligned_d;
  ctrl_t           ctrl;

  assign ctrl = '{branch: branch_i, branch_flag: branchFlag_i, jump: jump_i, jalr: jalr_i};

  branch_target_calc u_target (
    .pc           (pc_o),
    .imm          (imm_i),
    .rs1          (rs1_i),
    .ctrl         (ctrl),
    .target_c     (target),
    .misaligned_c (target_mis)
  );

  assign pcPlus4_o = pc_o + XLEN'(PC_STEP);

  // Next state and PC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_o;
    case (state_q)
      FETCH: if (imemAck_i) state_d = EXEC;
      EXEC: begin
        if (!stall_i) begin
          if (target_mis) begin
            state_d = TRAP;
          end else begin
            state_d = FETCH;
            pc_d    = target;
          end
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    imem_req_d   = (state_d == FETCH);
    misaligned_d = (state_d == TRAP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      pc_o         <= RESET_PC;
      imemReq_o    <= 1'b1;
      misaligned_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_o         <= pc_d;
      imemReq_o    <= imem_req_d;
      misaligned_o <= misaligned_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic              count_en;
  logic [STAT_W-1:0] branch_cnt_q;
  logic [STAT_W-1:0] taken_cnt_q;

  // Only non-stalled, non-trapping conditional-branch retirements count
  assign count_en = (state_q == EXEC) && !stall_i && branch_i && !target_mis;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (count_en) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + STAT_W'(1);
      if (branchFlag_i && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + STAT_W'(1);
    end
  end

  assign branchCount_o = branch_cnt_q;
  assign takenCount_o  = taken_cnt_q;
`else
  assign branchCount_o = '0;
  assign takenCount_o  = '0;
`endif

endmodule
